pucch1_spread: RTL and testbench
================================

Name: pucch1_spread

Overview:
- Generates the NR PUCCH format 1 time-domain orthogonal cover code phase index phi(m) per TS 38.211 Table 6.3.2.4.1-2, where w_i(m) = exp(j*2*pi*phi(m)/N_SF).
- After a start command it emits one phi value per next-request, for m = 0..nSF-1.
- Sits in the PUCCH format 1 transmit chain, feeding the spreading multiplier and phase-rotation lookup.

Parameters:
- NSF_W, 3, width of i_nSF and i_occi (N_SF max 7).
- PHI_W, 4, width of o_wi_phi (phi max 6).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse; latches i_nSF and i_occi and arms the sequence.
- i_next  in  1  request the next phi element; level-sensitive, one element per cycle while high.
- i_nSF  in  NSF_W  spreading factor N_SF, legal range 1..7; sampled only on i_start.
- i_occi  in  NSF_W  OCC index i, legal range 0..nSF-1; sampled only on i_start.
- o_wi_phi  out  PHI_W  phi(m) for the element currently presented.
- o_done  out  1  pulse coincident with the last element (m = nSF-1).
- o_valid  out  1  o_wi_phi holds a new element this cycle.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, o_wi_phi=0, o_valid=0, o_done=0, internal m=0, internal counters cleared.
- States: IDLE and RUN.
- IDLE, start handling:
  - i_start=1 with legal inputs: register nSF and occi, clear the element counter, go to RUN.
  - Illegal inputs (nSF=0 or occi>=nSF): i_start is ignored and the block stays in IDLE.
- RUN, element emission: each posedge with i_next=1 registers o_wi_phi=phi(k) and o_valid=1, and sets internal register m=k (m is always the index of the element on o_wi_phi). The counter k then increments.
  - Latency: one clock from the sampled i_next to o_valid.
- RUN with i_next=0: o_valid=0; o_wi_phi and m hold their values; the position is not lost.
- Last element (k = nSF-1): o_done=1 in the same cycle as o_valid, then return to IDLE. o_done is low in every other cycle.
- i_next in IDLE is ignored: o_valid stays 0 and o_wi_phi holds.
- i_start in RUN aborts the current sequence and restarts with the new inputs; no o_valid in that cycle.
- i_start and i_next in the same cycle: i_start wins.
- phi rule:
  - For nSF in {1,2,3,5,6,7}: phi(m) = (occi*m) mod nSF. Implement with a running accumulator: add occi each element, subtract nSF on overflow; no divider.
  - For nSF = 4, Walsh table:
    - occi0: 0 0 0 0
    - occi1: 0 2 0 2
    - occi2: 0 0 2 2
    - occi3: 0 2 2 0
- phi(0) = 0 always. nSF=1 produces a single element 0 with o_done and o_valid together.
- Output width: values 0..6, zero-extended to PHI_W.

Optional Feature:
- Macro: PUCCH1_SPREAD_ERR_EN.
- Defined: adds output port o_err (1 bit, reset 0). o_err pulses one cycle after an i_start carrying illegal nSF or occi, and after an i_next received in IDLE.
- Undefined: no o_err port; illegal starts and stray i_next are silently ignored exactly as described in Behaviour.

Decomposition:
- Package pucch1_pkg holds:
  - NSF_MAX=7, NSF_W, PHI_W;
  - the 4x4 Walsh phi constant table for N_SF=4;
  - a state enum typedef {IDLE, RUN}.
- One natural sub-module: pucch1_phi_step, a combinational block. Inputs: nSF, occi, current accumulator, element index. Output: next phi (modular accumulate or Walsh lookup).
- The top module holds the FSM, the counter, m and the output registers.

Test Plan:
- nSF=4, occi=3, start then i_next held 4 cycles -> valid sequence 0,2,2,0 with m=0..3; o_done only on the 4th; o_valid low afterwards.
- nSF=7, occi=3 -> 0,3,6,2,5,1,4. nSF=6, occi=4 -> 0,4,2,0,4,2. nSF=5, occi=2 -> 0,2,4,1,3.
- Sweep nSF=1..7 and every occi<nSF, with i_next held nSF cycles -> each sequence matches the table. Exactly nSF valids and one o_done per case. nSF=1 gives a single 0 with o_done=1.
- nSF=7, occi=1, i_next toggled 1,0,1 -> outputs 0, (hold, no valid), 1; m continuous.
- i_start mid-sequence (nSF=5, occi=1, after 2 elements) with new nSF=3, occi=2 -> next valids 0,2,1 and o_done on the 3rd.
- Illegal start (nSF=3, occi=5) then i_next -> no o_valid; o_err pulses if PUCCH1_SPREAD_ERR_EN. Async rst mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/pucch1_pkg.sv
// Shared constants, Walsh table and state type for the PUCCH format 1
// orthogonal-cover phase generator.
package pucch1_pkg;

  localparam int NSF_MAX = 7;
  localparam int NSF_W   = 3;
  localparam int PHI_W   = 4;

  localparam logic [PHI_W-1:0] P0 = PHI_W'(0);
  localparam logic [PHI_W-1:0] P2 = PHI_W'(2);

  // N_SF = 4 uses the length-4 Walsh codes: phase index 2 means a -1 chip.
  // Row = OCC index, column = element index.
  localparam logic [PHI_W-1:0] WALSH4 [4][4] = '{
    '{P0, P0, P0, P0},
    '{P0, P2, P0, P2},
    '{P0, P0, P2, P2},
    '{P0, P2, P2, P0}
  };

  typedef enum logic {IDLE, RUN} state_e;

endpackage

// File: rtl/pucch1_phi_step.sv
// Combinational phase step: presents phi for the current element and the
// accumulator value for the following one. The accumulator tracks
// (occi*k) mod nSF incrementally, so no divider is needed.
import pucch1_pkg::*;

module pucch1_phi_step (
  input  logic [NSF_W-1:0] i_nsf,
  input  logic [NSF_W-1:0] i_occi,
  input  logic [PHI_W-1:0] i_acc,
  input  logic [1:0]       i_idx,     // element index mod 4 (Walsh column)
  output logic [PHI_W-1:0] o_phi,
  output logic [PHI_W-1:0] o_acc_nxt
);

  logic [PHI_W:0] sum;
  logic [PHI_W:0] sum_sub;

  // acc < nSF and occi < nSF, so one conditional subtract keeps it in range
  always_comb begin
    sum       = {1'b0, i_acc} + (PHI_W+1)'(i_occi);
    sum_sub   = sum - (PHI_W+1)'(i_nsf);
    o_acc_nxt = (sum >= (PHI_W+1)'(i_nsf)) ? sum_sub[PHI_W-1:0] : sum[PHI_W-1:0];
    if (i_nsf == NSF_W'(4))
      o_phi = WALSH4[i_occi[1:0]][i_idx];
    else
      o_phi = i_acc;
  end

endmodule

// File: rtl/pucch1_spread.sv
// PUCCH format 1 time-domain OCC phase generator. After a legal i_start it
// emits phi(m), m = 0..nSF-1, one element per cycle while i_next is high.
// Optional feature macro: PUCCH1_SPREAD_ERR_EN adds o_err, a one-cycle
// pulse after an illegal i_start or an i_next received in IDLE.
import pucch1_pkg::*;

module pucch1_spread (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_next,
  input  logic [NSF_W-1:0] i_nSF,
  input  logic [NSF_W-1:0] i_occi,
  output logic [PHI_W-1:0] o_wi_phi,
  output logic             o_done,
`ifdef PUCCH1_SPREAD_ERR_EN
  output logic             o_err,
`endif
  output logic             o_valid
);

  state_e           state_q, state_d;
  logic [NSF_W-1:0] nsf_q, nsf_d;
  logic [NSF_W-1:0] occi_q, occi_d;
  logic [NSF_W-1:0] k_q, k_d;       // index of the next element to emit
  logic [NSF_W-1:0] m_q, m_d;       // index of the element on o_wi_phi
  logic [PHI_W-1:0] acc_q, acc_d;   // (occi*k) mod nSF
  logic [PHI_W-1:0] phi_q, phi_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
`ifdef PUCCH1_SPREAD_ERR_EN
  logic             err_q, err_d;
`endif

  logic             start_ok;
  logic [PHI_W-1:0] step_phi;
  logic [PHI_W-1:0] step_acc;

  pucch1_phi_step u_step (
    .i_nsf     (nsf_q),
    .i_occi    (occi_q),
    .i_acc     (acc_q),
    .i_idx     (k_q[1:0]),
    .o_phi     (step_phi),
    .o_acc_nxt (step_acc)
  );

  // Next-state and output decode; a legal start always wins over i_next.
  // An illegal start is dropped as if it never arrived.
  always_comb begin
    state_d  = state_q;
    nsf_d    = nsf_q;
    occi_d   = occi_q;
    k_d      = k_q;
    m_d      = m_q;
    acc_d    = acc_q;
    phi_d    = phi_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
`ifdef PUCCH1_SPREAD_ERR_EN
    err_d    = 1'b0;
`endif
    start_ok = (i_nSF != '0) && (i_occi < i_nSF);

    if (i_start && start_ok) begin
      nsf_d   = i_nSF;
      occi_d  = i_occi;
      k_d     = '0;
      acc_d   = '0;
      state_d = RUN;
    end else begin
`ifdef PUCCH1_SPREAD_ERR_EN
      if (i_start) err_d = 1'b1;
`endif
      case (state_q)
        RUN: begin
          if (i_next) begin
            phi_d   = step_phi;
            valid_d = 1'b1;
            m_d     = k_q;
            k_d     = k_q + NSF_W'(1);
            acc_d   = step_acc;
            if (k_q == nsf_q - NSF_W'(1)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: begin
`ifdef PUCCH1_SPREAD_ERR_EN
          if (i_next) err_d = 1'b1;
`endif
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      nsf_q   <= '0;
      occi_q  <= '0;
      k_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      phi_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef PUCCH1_SPREAD_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      nsf_q   <= nsf_d;
      occi_q  <= occi_d;
      k_q     <= k_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      phi_q   <= phi_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef PUCCH1_SPREAD_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign o_wi_phi = phi_q;
  assign o_valid  = valid_q;
  assign o_done   = done_q;
`ifdef PUCCH1_SPREAD_ERR_EN
  assign o_err    = err_q;
`endif

endmodule

// File: tb/tb_pucch1_spread.sv
// Bench for pucch1_spread: fixed vector table, full nSF/occi sweep against
// a reference model, and hand sequences for gaps, abort, illegal start and
// asynchronous reset. Expected elements go through a scoreboard queue.
module tb_pucch1_spread;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start, i_next;
  logic [2:0] i_nSF, i_occi;
  logic [3:0] o_wi_phi;
  logic       o_done, o_valid;
`ifdef PUCCH1_SPREAD_ERR_EN
  logic       o_err;
`endif

  pucch1_spread dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_next   (i_next),
    .i_nSF    (i_nSF),
    .i_occi   (i_occi),
    .o_wi_phi (o_wi_phi),
    .o_done   (o_done),
`ifdef PUCCH1_SPREAD_ERR_EN
    .o_err    (o_err),
`endif
    .o_valid  (o_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [4:0] q[$];   // {last, phi}

  typedef struct packed {
    logic [2:0]       nsf;
    logic [2:0]       occi;
    logic [6:0][3:0]  exp;  // element m in nibble m
  } vec_t;
  vec_t vt [4];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int phi_model(input int nsf, input int occi, input int m);
    if (nsf == 4) begin
      case (occi)
        1:       return (m % 2) * 2;
        2:       return (m / 2) * 2;
        3:       return ((m % 2) ^ (m / 2)) * 2;
        default: return 0;
      endcase
    end
    return (occi * m) % nsf;
  endfunction

  task automatic push_exp(input int phi, input bit last);
    q.push_back({last, 4'(phi)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a sequence, hold i_next for nsf cycles, then require an empty queue
  task automatic run_seq(input int nsf, input int occi);
    i_nSF   = 3'(nsf);
    i_occi  = 3'(occi);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_next  = 1'b1;
    repeat (nsf) tick();
    i_next  = 1'b0;
    repeat (2) tick();
    chk($sformatf("drain_%0d_%0d", nsf, occi), q.size(), 0);
  endtask

  // Scoreboard: every valid element must match the head of the queue
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got phi %0d done %0d expected no valid at %0t",
                   o_wi_phi, o_done, $time);
        end else begin
          logic [4:0] e;
          e = q.pop_front();
          chk("phi", int'(o_wi_phi), int'(e[3:0]));
          chk("done", int'(o_done), int'(e[4]));
        end
      end else if (o_done) begin
        tests++;
        fails++;
        $display("FAIL done_without_valid: got done 1 expected 0 at %0t", $time);
      end
    end
  end

  initial begin
    rst = 1'b1; i_start = 1'b0; i_next = 1'b0; i_nSF = '0; i_occi = '0;
    repeat (2) tick();
    chk("rst_phi",   int'(o_wi_phi), 0);
    chk("rst_valid", int'(o_valid),  0);
    chk("rst_done",  int'(o_done),   0);
`ifdef PUCCH1_SPREAD_ERR_EN
    chk("rst_err",   int'(o_err),    0);
`endif
    rst = 1'b0;
    tick();

    // Fixed vectors from hand-worked expected sequences
    vt[0] = '{3'd4, 3'd3, 28'h0000220};
    vt[1] = '{3'd7, 3'd3, 28'h4152630};
    vt[2] = '{3'd6, 3'd4, 28'h0240240};
    vt[3] = '{3'd5, 3'd2, 28'h0031420};
    for (int v = 0; v < 4; v++) begin
      for (int m = 0; m < int'(vt[v].nsf); m++)
        push_exp(int'(vt[v].exp[m]), m == int'(vt[v].nsf) - 1);
      run_seq(int'(vt[v].nsf), int'(vt[v].occi));
      chk("valid_low_after", int'(o_valid), 0);
    end

    // Full sweep of every legal (nSF, occi)
    for (int n = 1; n <= 7; n++)
      for (int o = 0; o < n; o++) begin
        for (int m = 0; m < n; m++) push_exp(phi_model(n, o, m), m == n - 1);
        run_seq(n, o);
      end

    // i_next gap: nSF=7 occi=1, pattern 1,1,0,1.. ; output holds through the gap
    for (int m = 0; m < 7; m++) push_exp(m, m == 6);
    i_nSF = 3'd7; i_occi = 3'd1; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_next = 1'b1;
    repeat (2) tick();
    i_next = 1'b0;
    tick();
    chk("gap_valid", int'(o_valid), 0);
    chk("gap_hold_phi", int'(o_wi_phi), 1);
    i_next = 1'b1;
    repeat (5) tick();
    i_next = 1'b0;
    repeat (2) tick();
    chk("gap_drain", q.size(), 0);

    // Abort: nSF=5 occi=1 for two elements, then restart with nSF=3 occi=2
    push_exp(0, 1'b0); push_exp(1, 1'b0);
    i_nSF = 3'd5; i_occi = 3'd1; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_next = 1'b1;
    repeat (2) tick();
    i_nSF = 3'd3; i_occi = 3'd2; i_start = 1'b1;  // i_next still high
    tick();
    chk("abort_no_valid", int'(o_valid), 0);
    i_start = 1'b0;
    push_exp(0, 1'b0); push_exp(2, 1'b0); push_exp(1, 1'b1);
    repeat (3) tick();
    i_next = 1'b0;
    repeat (2) tick();
    chk("abort_drain", q.size(), 0);

    // Illegal start (occi >= nSF) then stray i_next: nothing may be emitted
    i_nSF = 3'd3; i_occi = 3'd5; i_start = 1'b1;
    tick();
    i_start = 1'b0;
`ifdef PUCCH1_SPREAD_ERR_EN
    chk("err_illegal_start", int'(o_err), 1);
`endif
    i_next = 1'b1;
    tick();
`ifdef PUCCH1_SPREAD_ERR_EN
    chk("err_stray_next", int'(o_err), 1);
`endif
    repeat (2) tick();
    chk("illegal_no_valid", int'(o_valid), 0);
    i_next = 1'b0;
    // Illegal start with nSF=0
    i_nSF = 3'd0; i_occi = 3'd0; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_next = 1'b1;
    repeat (2) tick();
    i_next = 1'b0;
    tick();
    chk("nsf0_no_valid", int'(o_valid), 0);

    // Asynchronous reset in the middle of a run
    for (int m = 0; m < 7; m++) push_exp(m, m == 6);
    i_nSF = 3'd7; i_occi = 3'd1; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_next = 1'b1;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_phi",   int'(o_wi_phi), 0);
    chk("async_rst_valid", int'(o_valid),  0);
    chk("async_rst_done",  int'(o_done),   0);
    q.delete();
    i_next = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    i_next = 1'b1;
    repeat (2) tick();
    i_next = 1'b0;
    tick();
    chk("post_rst_idle", int'(o_valid), 0);

    // Recovery after reset
    for (int m = 0; m < 3; m++) push_exp(phi_model(3, 1, m), m == 2);
    run_seq(3, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
